bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 18, giving the binary operand width (valid range 4..32).
REQ-002 SHALL have derived localparam BCDW = BITS + (BITS-4)/3 + 1, giving the BCD result width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous abort, returns the block to IDLE.
REQ-006 SHALL have port in_valid, input, 1 bit: the operand on bin is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an operand.
REQ-008 SHALL have port bin, input, BITS bits: unsigned binary operand.
REQ-009 SHALL have port out_valid, output, 1 bit: bcd holds a completed result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port bcd, output, BCDW bits: packed BCD result, least-significant digit in bits [3:0].
REQ-012 SHALL have port busy, output, 1 bit: a conversion is in progress (CONV state).

Function
REQ-013 SHALL implement an FSM with states IDLE, CONV and DONE.
REQ-014 SHALL assert in_ready only in IDLE, and out_valid only in DONE.
REQ-015 SHALL accept an operand on an edge where in_valid && in_ready: capture bin into the shift register, clear the BCD accumulator to 0, load the iteration counter with BITS, and move to CONV.
REQ-016 SHALL, on each CONV edge, perform one double-dabble step:
- add 3 to every accumulator nibble whose value is >= 5;
- shift {accumulator, shift register} left by one bit;
- decrement the counter.
REQ-017 SHALL move from CONV to DONE on the edge that performs the BITS-th step, so out_valid rises exactly BITS edges after the accepting edge.
REQ-018 SHALL hold bcd and out_valid stable in DONE until out_valid && out_ready, then move to IDLE on that edge.
REQ-019 SHALL NOT accept a new operand on the same edge as result handoff (in_ready is low in DONE); maximum throughput is one result per BITS+2 cycles.
REQ-020 SHALL ignore in_valid in CONV and DONE, and ignore out_ready outside DONE.
REQ-021 SHALL, when clr is high on an edge, move to IDLE from any state and clear the counter, accumulator and shift register.
REQ-022 SHALL give clr priority over acceptance and handoff on the same edge; no result is presented.
REQ-023 SHALL keep bcd equal to the last completed result while in IDLE and CONV, and update bcd only on the transition into DONE.
REQ-024 SHALL truncate the internal accumulator to BCDW bits; for every BITS in range no digit overflow occurs.
REQ-025 SHALL produce results that match the combinational double-dabble value of bin for all inputs, including 0 and 2^BITS-1.

Reset
REQ-026 SHALL, while rst_n is low, immediately force: state IDLE, in_ready=1, out_valid=0, busy=0, bcd=0, counter=0, and internal registers 0.
REQ-027 SHALL abandon a conversion in progress when rst_n asserts; no partial result appears after release.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts, with in_ready=1.

Verification
REQ-029 SHALL verify, with BITS=18: bin=12345 accepted at edge k -> out_valid=1 after edge k+18, bcd=23'h012345, busy high for 18 cycles.
REQ-030 SHALL verify the boundaries: bin=0 -> bcd=0; bin=262143 -> bcd=23'h262143; bin=9 -> bcd=23'h000009; bin=10 -> bcd=23'h000010.
REQ-031 SHALL verify backpressure: out_ready held low 10 cycles after DONE -> bcd and out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next edge.
REQ-032 SHALL verify reset: rst_n pulsed low at CONV iteration 7 -> outputs take reset values without waiting for a clock; new bin=99 after release -> bcd=23'h000099.
REQ-033 SHALL verify clr: clr asserted in CONV -> IDLE next edge, no out_valid; clr together with out_ready in DONE -> IDLE, bcd cleared to 0.
REQ-034 SHALL verify back-to-back streaming: 1000 random operands with random out_ready -> every bcd matches the reference model, with no drops or duplicates.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter: accepts one operand, runs BITS double-dabble
// steps, then holds the packed BCD result until the consumer takes it.
module bcd_seq_ctrl #(
    parameter  int BITS = 18,
    localparam int BCDW = BITS + (BITS - 4) / 3 + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BCDW-1:0] bcd,
    output logic            busy
);
    // state | meaning
    // IDLE  | waiting for an operand, in_ready high
    // CONV  | one double-dabble step per edge, busy high
    // DONE  | result presented on bcd, out_valid high
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam int CW    = $clog2(BITS + 1);
    localparam int NFULL = BCDW / 4;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_cnt;
    logic [BCDW-1:0]        r_acc;
    logic [BITS-1:0]        r_sr;
    logic [BCDW-1:0]        r_bcd;
    logic [BCDW-1:0]        w_adj;
    logic [BCDW+BITS-1:0]   w_shift;
    logic                   w_last;

    // A partial top digit (at most 3 bits) never reaches 5 for any legal BITS,
    // so only the full nibbles need the add-3 correction.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < NFULL; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_shift = {w_adj, r_sr} << 1;
    assign w_last  = (r_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = CONV;
            CONV:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
        if (clr) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_sr  <= '0;
            r_bcd <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_sr  <= '0;
            r_bcd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sr  <= bin;
                        r_acc <= '0;
                        r_cnt <= CW'(BITS);
                    end
                end
                CONV: begin
                    r_acc <= w_shift[BCDW+BITS-1:BITS];
                    r_sr  <= w_shift[BITS-1:0];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_bcd <= w_shift[BCDW+BITS-1:BITS];
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == CONV);
    assign out_valid = (r_state == DONE);
    assign bcd       = r_bcd;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed and streaming bench for bcd_seq_ctrl; expected results come from a
// decimal-digit reference model through a scoreboard queue.
module tb_bcd_seq_ctrl;
    localparam int BITS = 18;
    localparam int BCDW = BITS + (BITS - 4) / 3 + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clr = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] bin = '0;
    logic            in_ready;
    logic            out_valid;
    logic            busy;
    logic [BCDW-1:0] bcd;

    int n_cmp = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_res = 0;
    logic [BCDW-1:0] sb[$];

    bcd_seq_ctrl #(.BITS(BITS)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd(bcd), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BCDW-1:0] ref_bcd(input logic [BITS-1:0] v);
        logic [63:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 16; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r[BCDW-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are sampled before the edge, scoreboard updated after it.
    task automatic tick();
        logic            hs_in;
        logic            hs_out;
        logic [BCDW-1:0] b;
        logic [BITS-1:0] v;
        hs_in  = in_valid && in_ready && !clr && rst_n;
        hs_out = out_valid && out_ready && !clr && rst_n;
        b = bcd;
        v = bin;
        if (clr) sb.delete();
        @(posedge clk);
        #1;
        if (hs_in) begin
            sb.push_back(ref_bcd(v));
            n_acc++;
        end
        if (hs_out) begin
            n_res++;
            check("queue_depth_at_handoff", 64'(sb.size()), 64'd1);
            if (sb.size() > 0) check("scoreboard_bcd", 64'(b), 64'(sb.pop_front()));
        end
    endtask

    task automatic wait_out(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) tick();
        check("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic run_op(input logic [BITS-1:0] v, input logic [63:0] exp, input string tag);
        bin = v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(40);
        check(tag, 64'(bcd), exp);
        tick();
        out_ready = 1'b0;
        check({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [BCDW-1:0] held;
        logic            seen;
        int              acc0;
        int              res0;

        // reset values
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        #20 rst_n = 1'b1;
        tick();

        // latency and busy window for 12345
        bin = 18'd12345;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= BITS; i++) begin
            check("lat_busy", 64'(busy), 64'd1);
            check("lat_no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_busy_low", 64'(busy), 64'd0);
        check("bcd_12345", 64'(bcd), 64'h012345);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_handoff_idle", 64'(in_ready), 64'd1);

        // boundaries
        run_op(18'd0,      64'h000000, "bcd_0");
        run_op(18'd262143, 64'h262143, "bcd_max");
        run_op(18'd9,      64'h000009, "bcd_9");
        run_op(18'd10,     64'h000010, "bcd_10");

        // backpressure
        bin = 18'd777;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out(40);
        held = bcd;
        check("bp_bcd", 64'(bcd), 64'h000777);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            bin = BITS'($urandom);
            tick();
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_bcd_stable", 64'(bcd), 64'(held));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);

        // asynchronous reset in the middle of a conversion
        bin = 18'd54321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("mid_conv_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_bcd", 64'(bcd), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (25) begin
            tick();
            seen = seen | out_valid | busy;
        end
        check("no_partial_after_rst", 64'(seen), 64'd0);
        run_op(18'd99, 64'h000099, "bcd_99");

        // clr during conversion
        bin = 18'd4321;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_conv_idle", 64'(in_ready), 64'd1);
        check("clr_conv_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (25) begin
            tick();
            seen = seen | out_valid;
        end
        check("clr_conv_no_valid", 64'(seen), 64'd0);

        // clr together with out_ready in DONE
        bin = 18'd555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(40);
        clr = 1'b1;
        out_ready = 1'b1;
        tick();
        clr = 1'b0;
        out_ready = 1'b0;
        check("clr_done_idle", 64'(in_ready), 64'd1);
        check("clr_done_valid", 64'(out_valid), 64'd0);
        check("clr_done_bcd", 64'(bcd), 64'd0);
        check("clr_done_queue", 64'(sb.size()), 64'd0);

        // random streaming
        acc0 = n_acc;
        res0 = n_res;
        for (int c = 0; c < 60000 && (n_acc - acc0) < 1000; c++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      bin = '0;
            else if (r == 1) bin = '1;
            else             bin = BITS'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        out_ready = 1'b0;
        check("stream_accepted", 64'(n_acc - acc0), 64'd1000);
        check("stream_results", 64'(n_res - res0), 64'd1000);
        check("stream_queue_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
